// File: rtl/uart_cmd_rx.sv
// UART receiver with drive-command decoder and link watchdog.
// Ports: clk, rst_n, rxd in; rx_data, rx_valid, frame_err, parity_err, driver, cmd_stale out.
module uart_cmd_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int TIMEOUT_MS = 500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [1:0]           driver,
  output logic                 cmd_stale
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] OVS_HALF = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OVS_LAST = OW'(OVERSAMPLE - 1);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam longint TO_CLK = longint'(CLK_HZ) / 1000 * TIMEOUT_MS;
  localparam int WW = (TO_CLK > 1) ? $clog2(TO_CLK + 1) : 1;
  localparam logic [WW-1:0] TO_W = WW'(TO_CLK);
  localparam bit WD_EN = (TIMEOUT_MS != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rxs;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [OW-1:0]        ovs;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 par_exp;
  logic [1:0]           cmd;
  logic [WW-1:0]        wd_cnt;

  assign rxs  = sync[1];
  assign tick = (div_cnt == DIV_LAST);

  // Odd parity: the parity bit makes the total count of ones odd.
  assign par_exp = (PARITY == 1) ? ~^shreg : ^shreg;

  assign cmd = (rx_data[DATA_BITS-1:2] == '0) ? rx_data[1:0] : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      div_cnt <= '0;
    end else begin
      sync    <= {sync[0], rxd};
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ovs        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      driver     <= 2'b00;
      cmd_stale  <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            ovs   <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (ovs == OVS_HALF) begin
              ovs <= '0;
              if (!rxs) begin
                state   <= S_DATA;
                bit_cnt <= '0;
                perr    <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              ovs <= ovs + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (ovs == OVS_LAST) begin
              ovs <= '0;
              // LSB first: shift right so bit 0 ends at the bottom.
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                state <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              ovs <= ovs + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (tick) begin
            if (ovs == OVS_LAST) begin
              ovs   <= '0;
              perr  <= (rxs != par_exp);
              state <= S_STOP;
            end else begin
              ovs <= ovs + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (ovs == OVS_LAST) begin
              ovs   <= '0;
              state <= S_IDLE;
              if (!rxs) begin
                frame_err <= 1'b1;
              end else if (perr) begin
                parity_err <= 1'b1;
              end else begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end
            end else begin
              ovs <= ovs + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Command decode and link watchdog.
      if (rx_valid) begin
        driver    <= cmd;
        cmd_stale <= 1'b0;
        wd_cnt    <= '0;
      end else if (WD_EN) begin
        if (wd_cnt == TO_W) begin
          driver    <= 2'b00;
          cmd_stale <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end
  end

endmodule
